// File: rtl/add8_err_monitor.sv
// rtl/add8_err_monitor.sv - error-statistics monitor for an approximate 8-bit adder
module add8_err_monitor #(
    parameter int CNT_W = 16,
    parameter int ACC_W = CNT_W + 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       A,
    input  logic [7:0]       B,
    input  logic [8:0]       O,
    input  logic             last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] abs_err_sum,
    output logic [ACC_W:0]   err_sum,
    output logic [8:0]       wce
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   drain_q, drain_d;
    logic   accept;

    // start wins over a same-cycle handshake, so the presented sample is dropped
    assign accept = in_valid && (state_q == S_RUN) && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (start) begin
            state_d = S_RUN;
            drain_d = 1'b0;
        end
    end

    logic       cap_vld_q;
    logic [7:0] cap_a_q;
    logic [7:0] cap_b_q;
    logic [8:0] cap_o_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_q <= 1'b0;
            cap_a_q   <= 8'd0;
            cap_b_q   <= 8'd0;
            cap_o_q   <= 9'd0;
        end else begin
            cap_vld_q <= accept;
            if (accept) begin
                cap_a_q <= A;
                cap_b_q <= B;
                cap_o_q <= O;
            end
        end
    end

    logic [8:0] exact_d;
    logic [9:0] diff_d;
    logic [8:0] absd_d;

    always_comb begin
        exact_d = {1'b0, cap_a_q} + {1'b0, cap_b_q};
        diff_d  = {1'b0, cap_o_q} - {1'b0, exact_d};
        // magnitude fits 9 bits: the most negative difference is -510
        absd_d  = diff_d[9] ? (~diff_d[8:0] + 9'd1) : diff_d[8:0];
    end

    logic       s1_vld_q;
    logic [9:0] s1_diff_q;
    logic [8:0] s1_absd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_diff_q <= 10'd0;
            s1_absd_q <= 9'd0;
        end else begin
            s1_vld_q <= cap_vld_q && !start;
            if (cap_vld_q) begin
                s1_diff_q <= diff_d;
                s1_absd_q <= absd_d;
            end
        end
    end

    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] abs_sum_q, abs_sum_d;
    logic [ACC_W:0]   err_sum_q, err_sum_d;
    logic [8:0]       wce_q, wce_d;
    logic [ACC_W:0]   abs_sum_w;
    logic [ACC_W+1:0] err_sum_w;
    logic             mis;

    assign mis = |s1_diff_q;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        abs_sum_d    = abs_sum_q;
        err_sum_d    = err_sum_q;
        wce_d        = wce_q;
        abs_sum_w    = {1'b0, abs_sum_q} + {{(ACC_W-8){1'b0}}, s1_absd_q};
        err_sum_w    = {err_sum_q[ACC_W], err_sum_q} + {{(ACC_W-8){s1_diff_q[9]}}, s1_diff_q};
        if (start) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            abs_sum_d    = '0;
            err_sum_d    = '0;
            wce_d        = '0;
        end else if (s1_vld_q) begin
            if (sample_cnt_q != {CNT_W{1'b1}}) begin
                sample_cnt_d = sample_cnt_q + CNT_W'(1);
            end
            if (mis && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            abs_sum_d = abs_sum_w[ACC_W] ? {ACC_W{1'b1}} : abs_sum_w[ACC_W-1:0];
            // signed overflow shows as disagreement between the two top bits
            if (err_sum_w[ACC_W+1] != err_sum_w[ACC_W]) begin
                err_sum_d = err_sum_w[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
            end else begin
                err_sum_d = err_sum_w[ACC_W:0];
            end
            if (s1_absd_q > wce_q) begin
                wce_d = s1_absd_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            abs_sum_q    <= '0;
            err_sum_q    <= '0;
            wce_q        <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            abs_sum_q    <= abs_sum_d;
            err_sum_q    <= err_sum_d;
            wce_q        <= wce_d;
        end
    end

    assign sample_cnt  = sample_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign abs_err_sum = abs_sum_q;
    assign err_sum     = err_sum_q;
    assign wce         = wce_q;

endmodule

// File: tb/tb_add8_err_monitor.sv
// tb/tb_add8_err_monitor.sv - randomized self-checking bench for add8_err_monitor
module tb_add8_err_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       last = 1'b0;
    logic [7:0] A = 8'd0;
    logic [7:0] B = 8'd0;
    logic [8:0] O = 9'd0;

    logic        rdy16, busy16, done16;
    logic [15:0] sc16, ec16;
    logic [24:0] abs16;
    logic [25:0] es16;
    logic [8:0]  w16;

    logic        rdy4, busy4, done4;
    logic [3:0]  sc4, ec4;
    logic [12:0] abs4;
    logic [13:0] es4;
    logic [8:0]  w4;

    add8_err_monitor #(.CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy16),
        .A(A), .B(B), .O(O), .last(last), .busy(busy16), .done(done16),
        .sample_cnt(sc16), .err_cnt(ec16), .abs_err_sum(abs16), .err_sum(es16), .wce(w16)
    );

    add8_err_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy4),
        .A(A), .B(B), .O(O), .last(last), .busy(busy4), .done(done4),
        .sample_cnt(sc4), .err_cnt(ec4), .abs_err_sum(abs4), .err_sum(es4), .wce(w4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int o;
    } smp_t;

    smp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Statistics of the current run, recomputed from every accepted sample
    task automatic model(input int cw, output longint sc, output longint ec,
                         output longint ab, output longint es, output longint w);
        longint maxc, maxa, esmin, d, ad;
        maxc  = (longint'(1) << cw) - 1;
        maxa  = (longint'(1) << (cw + 9)) - 1;
        esmin = -(maxa + 1);
        sc = 0; ec = 0; ab = 0; es = 0; w = 0;
        foreach (q[i]) begin
            d  = longint'(q[i].o) - longint'(q[i].a + q[i].b);
            ad = (d < 0) ? -d : d;
            if (sc < maxc) sc++;
            if (d != 0 && ec < maxc) ec++;
            ab = (ab + ad > maxa) ? maxa : ab + ad;
            es = es + d;
            if (es > maxa) es = maxa;
            if (es < esmin) es = esmin;
            if (ad > w) w = ad;
        end
    endtask

    task automatic check_stats(input string tag);
        longint sc, ec, ab, es, w;
        model(16, sc, ec, ab, es, w);
        chk({tag, ".sc16"}, 64'(sc16), sc);
        chk({tag, ".ec16"}, 64'(ec16), ec);
        chk({tag, ".abs16"}, 64'(abs16), ab);
        chk({tag, ".es16"}, 64'(es16), es & ((longint'(1) << 26) - 1));
        chk({tag, ".wce16"}, 64'(w16), w);
        model(4, sc, ec, ab, es, w);
        chk({tag, ".sc4"}, 64'(sc4), sc);
        chk({tag, ".ec4"}, 64'(ec4), ec);
        chk({tag, ".abs4"}, 64'(abs4), ab);
        chk({tag, ".es4"}, 64'(es4), es & ((longint'(1) << 14) - 1));
        chk({tag, ".wce4"}, 64'(w4), w);
    endtask

    task automatic chk_ctrl(input string tag, input bit r, input bit b, input bit d);
        chk({tag, ".rdy16"}, 64'(rdy16), 64'(r));
        chk({tag, ".busy16"}, 64'(busy16), 64'(b));
        chk({tag, ".done16"}, 64'(done16), 64'(d));
        chk({tag, ".rdy4"}, 64'(rdy4), 64'(r));
        chk({tag, ".busy4"}, 64'(busy4), 64'(b));
        chk({tag, ".done4"}, 64'(done4), 64'(d));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_o(input int a, input int b, output int o);
        int v;
        case ($urandom_range(2))
            0: o = a + b;
            1: begin
                v = a + b + int'($urandom_range(40)) - 20;
                o = (v < 0) ? 0 : ((v > 511) ? 511 : v);
            end
            default: o = int'($urandom_range(511));
        endcase
    endtask

    task automatic do_start(input string tag, input bit with_sample);
        int a, b, o;
        start = 1'b1;
        if (with_sample) begin
            a = int'($urandom_range(255));
            b = int'($urandom_range(255));
            rand_o(a, b, o);
            A = 8'(a); B = 8'(b); O = 9'(o);
            in_valid = 1'b1;
            last = 1'b1;
        end
        step();
        start = 1'b0;
        in_valid = 1'b0;
        last = 1'b0;
        q.delete();
        chk_ctrl({tag, ".start"}, 1'b1, 1'b1, 1'b0);
        check_stats({tag, ".start"});
    endtask

    task automatic send(input int a, input int b, input int o, input bit l);
        smp_t s;
        A = 8'(a); B = 8'(b); O = 9'(o);
        in_valid = 1'b1;
        last = l;
        step();
        in_valid = 1'b0;
        last = 1'b0;
        s.a = a; s.b = b; s.o = o;
        q.push_back(s);
    endtask

    task automatic finish_run(input string tag);
        chk_ctrl({tag, ".T0"}, 1'b0, 1'b1, 1'b0);
        step();
        chk_ctrl({tag, ".T1"}, 1'b0, 1'b1, 1'b0);
        step();
        chk_ctrl({tag, ".T2"}, 1'b0, 1'b0, 1'b1);
        check_stats({tag, ".final"});
    endtask

    task automatic idle_pulses(input string tag, input bit exp_done);
        for (int i = 0; i < 4; i++) begin
            A = 8'($urandom); B = 8'($urandom); O = 9'($urandom);
            in_valid = 1'b1;
            last = 1'($urandom_range(1));
            step();
        end
        in_valid = 1'b0;
        last = 1'b0;
        step();
        step();
        chk_ctrl(tag, 1'b0, 1'b0, exp_done);
        check_stats(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, o, gap;

        step();
        step();
        chk_ctrl("reset", 1'b0, 1'b0, 1'b0);
        check_stats("reset");
        rst_n = 1'b1;
        step();
        idle_pulses("idle", 1'b0);

        do_start("exact", 1'b0);
        send(3, 4, 7, 1'b0);
        send(255, 255, 510, 1'b0);
        send(0, 0, 0, 1'b0);
        send(128, 1, 129, 1'b1);
        finish_run("exact");

        do_start("mixed", 1'b0);
        send(3, 4, 0, 1'b0);
        chk("mixed.lat0", 64'(sc16), 64'd0);
        step();
        chk("mixed.lat1", 64'(sc16), 64'd0);
        step();
        check_stats("mixed.lat2");
        send(10, 10, 35, 1'b0);
        send(1, 1, 2, 1'b1);
        finish_run("mixed");
        chk("mixed.ec_const", 64'(ec16), 64'd2);
        chk("mixed.abs_const", 64'(abs16), 64'd22);
        chk("mixed.es_const", 64'(es16), 64'd8);
        chk("mixed.wce_const", 64'(w16), 64'd15);

        do_start("extreme", 1'b0);
        send(255, 255, 0, 1'b0);
        send(0, 0, 511, 1'b1);
        finish_run("extreme");
        idle_pulses("done_idle", 1'b1);

        do_start("restart", 1'b0);
        for (int i = 0; i < 5; i++) begin
            a = int'($urandom_range(255));
            b = int'($urandom_range(255));
            rand_o(a, b, o);
            send(a, b, o, 1'b0);
        end
        do_start("restart.mid", 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ctrl($sformatf("restart.flush%0d", i), 1'b1, 1'b1, 1'b0);
            check_stats($sformatf("restart.flush%0d", i));
        end
        send(9, 9, 20, 1'b1);
        finish_run("restart");

        do_start("drainrst", 1'b0);
        send(1, 2, 3, 1'b0);
        send(5, 5, 0, 1'b1);
        do_start("drainrst.mid", 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ctrl($sformatf("drainrst.hold%0d", i), 1'b1, 1'b1, 1'b0);
            check_stats($sformatf("drainrst.hold%0d", i));
        end
        send(7, 7, 14, 1'b1);
        finish_run("drainrst");

        do_start("sat1", 1'b0);
        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(255));
            b = int'($urandom_range(255));
            send(a, b, a + b + 1, i == 19);
        end
        finish_run("sat1");
        chk("sat1.sc4_const", 64'(sc4), 64'd15);
        chk("sat1.abs4_const", 64'(abs4), 64'd20);

        do_start("satpos", 1'b0);
        for (int i = 0; i < 20; i++) send(0, 0, 511, i == 19);
        finish_run("satpos");

        do_start("satneg", 1'b0);
        for (int i = 0; i < 20; i++) send(255, 255, 0, i == 19);
        finish_run("satneg");

        do_start("rnd", 1'b0);
        for (int i = 0; i < 40; i++) begin
            gap = int'($urandom_range(3));
            for (int g = 0; g < gap; g++) begin
                last = 1'($urandom_range(1));
                step();
            end
            last = 1'b0;
            if (gap >= 2) check_stats($sformatf("rnd.mid%0d", i));
            a = int'($urandom_range(255));
            b = int'($urandom_range(255));
            rand_o(a, b, o);
            send(a, b, o, i == 39);
        end
        finish_run("rnd");

        do_start("rstmid", 1'b0);
        send(4, 4, 1, 1'b0);
        send(6, 6, 12, 1'b0);
        send(200, 100, 7, 1'b0);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk_ctrl("rstmid.async", 1'b0, 1'b0, 1'b0);
        check_stats("rstmid.async");
        step();
        rst_n = 1'b1;
        step();
        step();
        chk_ctrl("rstmid.idle", 1'b0, 1'b0, 1'b0);
        idle_pulses("rstmid.pulse", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
